// File: rtl/rvj1_defines.sv
// Shared constants and types for the RVJ1 instruction fetch path.
//   XLEN            datapath width
//   IFU_FIFO_DEPTH  default instruction buffer depth
//   RVJ1_BOOT_ADDR  default first fetch address after reset
package rvj1_defines;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned IFU_FIFO_DEPTH = 2;
    localparam logic [XLEN-1:0] RVJ1_BOOT_ADDR = 32'h0000_0000;

    // One buffered fetch: the word and the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifu_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/rvj1_fifo.sv
// Small synchronous FIFO with synchronous flush.
//   clk_i, rst_i  clock, synchronous active-high reset
//   flush_i       drop all contents this cycle (wins over push/pop)
//   push_i/wdata_i  write one entry
//   pop_i         remove the head entry
//   rdata_o       head entry (meaningful only when !empty_o)
//   empty_o       no entries held
//   count_o       number of entries held
module rvj1_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full;
    logic             do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CntW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push_i, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q decides what is visible.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // The producer throttles requests so a push never meets a full buffer.
    assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full && !flush_i));

endmodule

// File: rtl/rvj1_ifu.sv
// Instruction fetch unit: issues word reads, buffers returned words with their
// PC and hands them to the decoder over a valid/ready interface.
//   clk_i, rst_i     clock, synchronous active-high reset
//   imem_en_o/addr_o read request; imem_rdata_i returns one cycle later
//   jmp_valid_i/addr_i redirect: flush buffer, squash in-flight read, new PC
//   ifu_instr_o/pc_o/valid_o, ifu_ready_i  decoder handshake
module rvj1_ifu
    import rvj1_defines::*;
#(
    parameter logic [XLEN-1:0] BOOT_ADDR  = RVJ1_BOOT_ADDR,
    parameter int unsigned     FIFO_DEPTH = IFU_FIFO_DEPTH
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_en_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            jmp_valid_i,
    input  logic [XLEN-1:0] jmp_addr_i,
    output logic [XLEN-1:0] ifu_instr_o,
    output logic [XLEN-1:0] ifu_pc_o,
    output logic            ifu_valid_o,
    input  logic            ifu_ready_i
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            inflight_q;
    logic [XLEN-1:0] inflight_pc_q;
    logic [CntW-1:0] fifo_count;
    logic            fifo_empty;
    logic            pop;
    logic            push;
    logic [CntW:0]   occupancy;
    ifu_entry_t      push_entry;
    ifu_entry_t      head_entry;

    assign pop = ifu_valid_o && ifu_ready_i;

    // Entries held plus the read still on its way, minus the one leaving now.
    assign occupancy = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q}
                     - {{CntW{1'b0}}, pop};

    assign imem_en_o   = !rst_i && !jmp_valid_i && (occupancy < (CntW + 1)'(FIFO_DEPTH));
    assign imem_addr_o = pc_q;

    // A redirect in the response cycle squashes the returning word.
    assign push             = inflight_q && !jmp_valid_i && !rst_i;
    assign push_entry.pc    = inflight_pc_q;
    assign push_entry.instr = imem_rdata_i;

    always_comb begin
        pc_d = pc_q;
        if (jmp_valid_i) begin
            pc_d = word_align(jmp_addr_i);
        end else if (imem_en_o) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q          <= word_align(BOOT_ADDR);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= imem_en_o;
            inflight_pc_q <= pc_q;
        end
    end

    rvj1_fifo #(
        .WIDTH ($bits(ifu_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (jmp_valid_i),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Outputs read as zero whenever nothing valid is presented.
    assign ifu_valid_o = !rst_i && !fifo_empty;
    assign ifu_instr_o = ifu_valid_o ? head_entry.instr : '0;
    assign ifu_pc_o    = ifu_valid_o ? head_entry.pc : '0;

endmodule
